dm_store: RTL and testbench
===========================

Name: dm_store

Overview:
- Memory-stage data memory and store unit for the 5-stage MIPS pipeline; the write side of the load path.
- Decodes the MEM-stage instruction, aligns sw/sh/sb data into byte lanes and writes little-endian word storage with per-byte enables.
- Returns the raw word on readdatam; the writeback load extender uses it with aluout[1:0] to form lw/lh/lhu/lb/lbu results.
- Flags misaligned stores and emits a one-cycle registered store-log record for the test harness.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- instrm  input  32  MEM-stage instruction
- pcm  input  32  MEM-stage PC
- aluoutm  input  32  effective byte address
- writedatam  input  32  rt value to store
- readdatam  output  32  raw word at the addressed word index, combinational
- misalignm  output  1  current instruction is a misaligned store, combinational
- errsticky  output  1  registered; set by any misaligned store
- stlogvalid  output  1  registered; a store committed on the previous edge
- stlogpc  output  32  registered PC of the logged store
- stlogaddr  output  32  registered word-aligned byte address, {aluoutm[31:2],2'b00}
- stlogdata  output  32  registered full word after merge

Behaviour:
- Opcode decode on instrm[31:26]:
  - sw = 6'b101011, sh = 6'b101001, sb = 6'b101000.
  - All other opcodes, including loads, never write.
- Word index = aluoutm[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Read path: readdatam = mem[index], combinational, for every instruction.
- Byte enables, where k = aluoutm[1:0]:
  - sw: 4'b1111, data = writedatam.
  - sh: aluoutm[1]=0 gives 4'b0011; aluoutm[1]=1 gives 4'b1100. writedatam[15:0] is replicated to both halves.
  - sb: enable bit k only. writedatam[7:0] is replicated to all lanes.
  - Lane k is bits 8k+7:8k.
- Misalignment:
  - misalignm = (sw & aluoutm[1:0]!=0) | (sh & aluoutm[0]).
  - A misaligned store writes nothing and produces no log record.
  - On the edge, errsticky <= 1; it clears only on reset.
- Write timing: enabled lanes update at the rising edge. Disabled lanes keep their value.
- Read during write, same address: readdatam shows the old word in that cycle and the new word from the next cycle.
- Store log: at the write edge, stlogvalid<=1, stlogpc<=pcm, stlogaddr<=aligned address, stlogdata<=merged word. In any cycle with no committed store, stlogvalid<=0 and the other log fields hold.
- Reset (synchronous, any cycle, including one carrying a store):
  - All memory words <= 0.
  - errsticky, stlogvalid <= 0; stlogpc, stlogaddr, stlogdata <= 0.
  - A store presented in the reset cycle is dropped.
- Back-to-back stores to the same word in consecutive cycles merge correctly, because each merge uses the current mem contents.
- Latency: store visible one cycle after the write edge. No stalls and no handshake; one instruction per cycle.

Test Plan:
- Reset, then lw at 0x10 (instr 0x8C000010) -> readdatam=0x00000000, stlogvalid=0, errsticky=0.
- sw 0xDEADBEEF to 0x20 -> next cycle stlogvalid=1, stlogaddr=0x20, stlogdata=0xDEADBEEF; a following read at 0x20 returns 0xDEADBEEF.
- After the above, sb 0x12 to 0x21, then sh 0x3456 to 0x22 in consecutive cycles -> logs 0xDEAD12EF then 0x345612EF; readdatam=0x345612EF.
- sw to 0x22, sh to 0x23 and sb to 0x23 over a word holding 0x345612EF at 0x20:
  - sw/0x22 and sh/0x23 -> misalignm=1, word unchanged, stlogvalid=0, errsticky=1 persists.
  - sb/0x23 is legal -> writes lane 3.
- Address wrap with ADDR_W=10: sw 0xA5A5A5A5 to 0x1000 -> read at 0x0 returns 0xA5A5A5A5.
- Assert reset together with sw 0x1 to 0x40 -> word 0x40 reads 0, stlogvalid=0, errsticky=0 after release.

Source files
------------

// File: rtl/dm_store.sv
// rtl/dm_store.sv - MEM-stage data memory with sw/sh/sb lane merge, misalign flag and store log
module dm_store #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrm,
  input  logic [31:0] pcm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] readdatam,
  output logic        misalignm,
  output logic        errsticky,
  output logic        stlogvalid,
  output logic [31:0] stlogpc,
  output logic [31:0] stlogaddr,
  output logic [31:0] stlogdata
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [5:0]        opcode;
  logic              is_sw, is_sh, is_sb, commit;
  logic [3:0]        be;
  logic [31:0]       wdata, merged;
  logic              unused_bits;

  assign opcode = instrm[31:26];
  assign is_sw  = (opcode == OP_SW);
  assign is_sh  = (opcode == OP_SH);
  assign is_sb  = (opcode == OP_SB);
  assign idx    = aluoutm[ADDR_W+1:2];

  assign readdatam   = mem[idx];
  assign misalignm   = (is_sw & (aluoutm[1:0] != 2'b00)) | (is_sh & aluoutm[0]);
  assign commit      = (is_sw | is_sh | is_sb) & ~misalignm;
  assign unused_bits = ^{instrm[25:0], aluoutm[31:ADDR_W+2]};

  // Data is replicated across lanes so the enable mask alone selects the target.
  always_comb begin
    be    = 4'b0000;
    wdata = writedatam;
    if (is_sw) begin
      be    = 4'b1111;
      wdata = writedatam;
    end else if (is_sh) begin
      be    = aluoutm[1] ? 4'b1100 : 4'b0011;
      wdata = {2{writedatam[15:0]}};
    end else if (is_sb) begin
      be    = 4'b0001 << aluoutm[1:0];
      wdata = {4{writedatam[7:0]}};
    end
  end

  always_comb begin
    merged = readdatam;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errsticky  <= 1'b0;
      stlogvalid <= 1'b0;
      stlogpc    <= '0;
      stlogaddr  <= '0;
      stlogdata  <= '0;
    end else begin
      stlogvalid <= commit;
      if (misalignm) errsticky <= 1'b1;
      if (commit) begin
        stlogpc   <= pcm;
        stlogaddr <= {aluoutm[31:2], 2'b00};
        stlogdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dm_store.sv
// tb/tb_dm_store.sv - scoreboard bench for dm_store with directed store/load vectors
module tb_dm_store;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrm, pcm, aluoutm, writedatam;
  logic [31:0] readdatam, stlogpc, stlogaddr, stlogdata;
  logic        misalignm, errsticky, stlogvalid;

  dm_store #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .instrm(instrm), .pcm(pcm), .aluoutm(aluoutm),
    .writedatam(writedatam), .readdatam(readdatam), .misalignm(misalignm),
    .errsticky(errsticky), .stlogvalid(stlogvalid), .stlogpc(stlogpc),
    .stlogaddr(stlogaddr), .stlogdata(stlogdata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LW = 32'h8C00_0000;
  localparam logic [31:0] SW = 32'hAC00_0000;
  localparam logic [31:0] SH = 32'hA400_0000;
  localparam logic [31:0] SB = 32'hA000_0000;

  // Expected view of the DUT during one instruction cycle: combinational
  // outputs for this instruction, registered outputs from the previous edge.
  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        err;
    logic        lv;
    logic [31:0] lpc;
    logic [31:0] laddr;
    logic [31:0] ldata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic issue(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic mis, input logic err,
                       input logic lv, input logic [31:0] lpc,
                       input logic [31:0] laddr, input logic [31:0] ldata);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; instrm = ins; pcm = pc; aluoutm = addr; writedatam = wd;
    e.rd = rd; e.mis = mis; e.err = err; e.lv = lv;
    e.lpc = lpc; e.laddr = laddr; e.ldata = ldata;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("readdatam", readdatam, e.rd);
        chk("misalignm", {31'b0, misalignm}, {31'b0, e.mis});
        chk("errsticky", {31'b0, errsticky}, {31'b0, e.err});
        chk("stlogvalid", {31'b0, stlogvalid}, {31'b0, e.lv});
        chk("stlogpc", stlogpc, e.lpc);
        chk("stlogaddr", stlogaddr, e.laddr);
        chk("stlogdata", stlogdata, e.ldata);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    reset = 1'b1; instrm = '0; pcm = '0; aluoutm = '0; writedatam = '0;
    repeat (2) @(posedge clk);
    //     rst instr pc        addr        wdata          readdatam    mis err lv log pc     log addr     log data
    issue(0, LW, 32'h0FC, 32'h10,   32'h0,         32'h00000000, 0, 0, 0, 32'h000, 32'h0000, 32'h00000000);
    issue(0, SW, 32'h100, 32'h20,   32'hDEADBEEF,  32'h00000000, 0, 0, 0, 32'h000, 32'h0000, 32'h00000000);
    issue(0, LW, 32'h104, 32'h20,   32'h0,         32'hDEADBEEF, 0, 0, 1, 32'h100, 32'h0020, 32'hDEADBEEF);
    issue(0, SB, 32'h108, 32'h21,   32'h00000012,  32'hDEADBEEF, 0, 0, 0, 32'h100, 32'h0020, 32'hDEADBEEF);
    issue(0, SH, 32'h10C, 32'h22,   32'h00003456,  32'hDEAD12EF, 0, 0, 1, 32'h108, 32'h0020, 32'hDEAD12EF);
    issue(0, LW, 32'h110, 32'h20,   32'h0,         32'h345612EF, 0, 0, 1, 32'h10C, 32'h0020, 32'h345612EF);
    issue(0, SW, 32'h114, 32'h22,   32'hFFFFFFFF,  32'h345612EF, 1, 0, 0, 32'h10C, 32'h0020, 32'h345612EF);
    issue(0, SH, 32'h118, 32'h23,   32'h0000FFFF,  32'h345612EF, 1, 1, 0, 32'h10C, 32'h0020, 32'h345612EF);
    issue(0, SB, 32'h11C, 32'h23,   32'h00000077,  32'h345612EF, 0, 1, 0, 32'h10C, 32'h0020, 32'h345612EF);
    issue(0, LW, 32'h120, 32'h20,   32'h0,         32'h775612EF, 0, 1, 1, 32'h11C, 32'h0020, 32'h775612EF);
    issue(0, SW, 32'h124, 32'h1000, 32'hA5A5A5A5,  32'h00000000, 0, 1, 0, 32'h11C, 32'h0020, 32'h775612EF);
    issue(0, LW, 32'h128, 32'h0,    32'h0,         32'hA5A5A5A5, 0, 1, 1, 32'h124, 32'h1000, 32'hA5A5A5A5);
    issue(1, SW, 32'h12C, 32'h40,   32'h00000001,  32'h00000000, 0, 1, 0, 32'h124, 32'h1000, 32'hA5A5A5A5);
    issue(0, LW, 32'h130, 32'h40,   32'h0,         32'h00000000, 0, 0, 0, 32'h000, 32'h0000, 32'h00000000);
    issue(0, LW, 32'h134, 32'h20,   32'h0,         32'h00000000, 0, 0, 0, 32'h000, 32'h0000, 32'h00000000);
    issue(0, LW, 32'h138, 32'h0,    32'h0,         32'h00000000, 0, 0, 0, 32'h000, 32'h0000, 32'h00000000);
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
